shl32_seq: RTL and testbench
============================

# shl32_seq

Multi-cycle 32-bit left shifter/rotator for the CPU datapath. It is the left-direction counterpart of the combinational `shr32` logical right shifter, and handles the `shl`/`rol` ALU ops. It trades area for latency by shifting at most `STEP` bits per clock. The control unit drives it with a start/done handshake and waits on `done` before writing the result to the register file.

## Interface
Parameters:
- `STEP`, default 1: maximum bits shifted per cycle. Legal values are 1, 2, 4 and 8; any other value fails elaboration.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `clr_n`: input, 1 bit. Reset, asynchronous and active-low.
- `start`: input, 1 bit. Request a new operation. Sampled on the rising edge.
- `mode`: input, 1 bit. 0 = SHL (logical shift left, zero fill); 1 = ROL (rotate left).
- `Ra`: input, 32 bits. Operand, captured when `start` is accepted.
- `shift_amt`: input, 5 bits. Shift count 0–31, captured when `start` is accepted.
- `busy`: output, 1 bit. High while in SHIFT.
- `done`: output, 1 bit. One-cycle pulse; `result` is valid in this cycle.
- `result`: output, 32 bits. Shifted/rotated value. Held stable until the next accepted `start`.

## Operation
- Single clock `clk`. Reset `clr_n` is asynchronous, active-low.
- On reset:
  - state = IDLE
  - `busy` = 0, `done` = 0, `result` = 32'h0
  - internal accumulator and remaining-count registers = 0
- FSM states are IDLE, SHIFT and DONE.
  - **IDLE**: `start`=1 is accepted.
    - Load acc←`Ra`, rem←`shift_amt`, and latch `mode`.
    - Go to DONE if `shift_amt`=0, else go to SHIFT.
  - **SHIFT**: each edge computes n = min(STEP, rem).
    - SHL: acc←acc<<n (zero fill).
    - ROL: acc←{acc[31-n:0], acc[31:32-n]}.
    - rem←rem−n.
    - When rem−n = 0, `result`←shifted acc and go to DONE.
  - **DONE**: `done`=1 for exactly one cycle.
    - Next state is IDLE.
    - A `start` in this cycle is also accepted, with the same rules as IDLE; back-to-back ops are allowed.
- In the shift-0 path, `result`←`Ra` on entry to DONE.
- `start` while in SHIFT is ignored. The in-flight operation is unaffected and there is no queuing.
- `mode`, `Ra` and `shift_amt` are don't-care except on the accepting edge.
- rem is 5 bits and never underflows, because n ≤ rem.
- ROL by 0 returns the operand unchanged. SHL never produces 1s in low bits.
- Reset asserted mid-operation aborts immediately: all outputs and registers return to reset values and no `done` is produced.

## Timing
- Let the accept edge be E0.
- Number of SHIFT cycles k = ceil(`shift_amt`/STEP).
- `done` is high in the cycle after edge E(k+1) minus 1. That is, `done` asserts k+1 cycles after the accept edge. `shift_amt`=0 gives latency 1.
- Worst case (STEP=1, `shift_amt`=31): 32 cycles. With STEP=8: 5 cycles.
- `busy` is high for exactly k cycles. `busy` and `done` are never both high.
- `result` changes only on the edge entering DONE, and on reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `shift_pkg`:
  - mode constants `SH_SHL`=1'b0, `SH_ROL`=1'b1
  - FSM state encoding `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2
  - the legal-STEP check function
- One sub-module `shl_step`: a combinational single-step shifter.
  - Inputs: 32-bit value, shift count n (0..STEP), mode.
  - Output: 32-bit value.
  - It is instantiated once. The top level contains only the FSM, the acc/rem registers and the output registers.

## Test plan
- Reset release, then STEP=1, SHL, `Ra`=32'h00000001, `shift_amt`=31 → `busy` high for 31 cycles; `done` 32 cycles after the accept edge; `result`=32'h80000000.
- STEP=1, SHL, `Ra`=32'hF0F0F0F0, `shift_amt`=4 → `result`=32'h0F0F0F00, `done` after 5 cycles; then `shift_amt`=0 → `result`=32'hF0F0F0F0, `done` after 1 cycle with `busy` never high.
- STEP=4, ROL, `Ra`=32'h80000001, `shift_amt`=31 → 8 SHIFT cycles (7×4 + 3); `result`=32'hC0000000, `done` after 9 cycles.
- STEP=1, ROL, `Ra`=32'hAAAAAAAA, `shift_amt`=1 → `result`=32'h55555555. `start` is pulsed again during SHIFT with `Ra`=32'h0; it is ignored and `result` is unchanged. A new `start` in the `done` cycle is accepted.
- STEP=2: start SHL with `Ra`=32'hFFFFFFFF, `shift_amt`=20, and pull `clr_n` low at cycle 5 → `busy`, `done` and `result` go to 0 immediately; no `done` follows. After release, a fresh op with `Ra`=32'h1 and `shift_amt`=3 gives `result`=32'h8.

Source files
------------

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle shifter datapath blocks.
//   - SH_SHL / SH_ROL : operation select encodings
//   - sh_state_e      : FSM state encoding for the sequential shifter
//   - step_is_legal() : checks that a per-cycle shift step is supported
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam logic SH_SHL = 1'b0;
    localparam logic SH_ROL = 1'b1;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sh_state_e;

    // Only power-of-two steps up to one byte are supported by the step shifter.
    function automatic logic step_is_legal(input int step);
        logic ok;
        case (step)
            32'sd1, 32'sd2, 32'sd4, 32'sd8: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/shl_step.sv
// -----------------------------------------------------------------------------
// shl_step
// Combinational single-step left shifter / rotator.
// Ports:
//   value_i [31:0] : value to shift
//   n_i     [4:0]  : shift count for this step (0..STEP)
//   mode_i         : SH_SHL (zero fill) or SH_ROL (rotate)
//   value_o [31:0] : shifted / rotated value
// -----------------------------------------------------------------------------
module shl_step
    import shift_pkg::*;
(
    input  logic [31:0] value_i,
    input  logic [4:0]  n_i,
    input  logic        mode_i,
    output logic [31:0] value_o
);

    logic [31:0] shl_s;
    logic [31:0] wrap_s;
    logic [5:0]  wrap_amt_s;

    // Rotate is the left shift OR'ed with the bits that fell off the top.
    // For n = 0 the wrap amount is 32, which shifts everything out and
    // leaves the operand unchanged.
    always_comb begin
        shl_s      = value_i << n_i;
        wrap_amt_s = 6'd32 - {1'b0, n_i};
        wrap_s     = value_i >> wrap_amt_s;
        if (mode_i == SH_ROL) begin
            value_o = shl_s | wrap_s;
        end else begin
            value_o = shl_s;
        end
    end

endmodule

// File: rtl/shl32_seq.sv
// -----------------------------------------------------------------------------
// shl32_seq
// Multi-cycle 32-bit logical left shifter / left rotator. Shifts at most
// STEP bits per clock and reports completion with a one-cycle done pulse.
// Parameters:
//   STEP : bits shifted per cycle, one of 1, 2, 4, 8
// Ports:
//   clk            : rising-edge clock
//   clr_n          : asynchronous active-low reset
//   start          : request a new operation (accepted in IDLE or DONE)
//   mode           : 0 = SHL, 1 = ROL
//   Ra [31:0]      : operand, captured on accept
//   shift_amt[4:0] : shift count, captured on accept
//   busy           : high while shifting
//   done           : one-cycle pulse, result valid
//   result [31:0]  : shifted value, held until the next accepted op
// -----------------------------------------------------------------------------
module shl32_seq
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] Ra,
    input  logic [4:0]  shift_amt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    generate
        if (!step_is_legal(STEP)) begin : g_bad_step
            $error("shl32_seq: STEP must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    sh_state_e   state_q,  state_d;
    logic [31:0] acc_q,    acc_d;
    logic [4:0]  rem_q,    rem_d;
    logic        mode_q,   mode_d;
    logic [31:0] result_q, result_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    logic [4:0]  n_s;
    logic [4:0]  rem_left_s;
    logic [31:0] step_s;
    logic        accept_s;

    // Per-cycle step count: never more than what remains, so rem cannot wrap.
    always_comb begin
        if (rem_q < STEP_AMT) begin
            n_s = rem_q;
        end else begin
            n_s = STEP_AMT;
        end
        rem_left_s = rem_q - n_s;
    end

    shl_step u_step (
        .value_i (acc_q),
        .n_i     (n_s),
        .mode_i  (mode_q),
        .value_o (step_s)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        result_d = result_q;
        // A start in the DONE cycle is honoured, giving back-to-back ops.
        accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    acc_d  = Ra;
                    rem_d  = shift_amt;
                    mode_d = mode;
                    if (shift_amt == 5'd0) begin
                        result_d = Ra;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = step_s;
                rem_d = rem_left_s;
                if (rem_left_s == 5'd0) begin
                    result_d = step_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are derived from the next state so they are registered.
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= 32'h0000_0000;
            rem_q    <= 5'd0;
            mode_q   <= SH_SHL;
            result_q <= 32'h0000_0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shl32_seq.sv
// -----------------------------------------------------------------------------
// tb_shl32_seq
// Directed bench for shl32_seq. Three instances share the clock and reset:
//   index 0 : STEP = 1
//   index 1 : STEP = 4
//   index 2 : STEP = 2
// Latency counts the accept edge's following cycle as 1.
// -----------------------------------------------------------------------------
module tb_shl32_seq;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start_v  [3];
    logic        mode_v   [3];
    logic [31:0] ra_v     [3];
    logic [4:0]  amt_v    [3];
    logic        busy_v   [3];
    logic        done_v   [3];
    logic [31:0] result_v [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shl32_seq #(.STEP(1)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .start(start_v[0]), .mode(mode_v[0]),
        .Ra(ra_v[0]), .shift_amt(amt_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
    );

    shl32_seq #(.STEP(4)) u_dut4 (
        .clk(clk), .clr_n(clr_n), .start(start_v[1]), .mode(mode_v[1]),
        .Ra(ra_v[1]), .shift_amt(amt_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
    );

    shl32_seq #(.STEP(2)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .start(start_v[2]), .mode(mode_v[2]),
        .Ra(ra_v[2]), .shift_amt(amt_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .result(result_v[2])
    );

    // Stimulus only: issue one op on instance w (called #1 after a rising
    // edge) and return latency, busy-cycle count, result and busy/done overlap.
    task automatic run_op(input int w, input logic m, input logic [31:0] a,
                          input logic [4:0] amt, output int lat, output int nbusy,
                          output logic [31:0] res, output logic ovl);
        mode_v[w]  = m;
        ra_v[w]    = a;
        amt_v[w]   = amt;
        start_v[w] = 1'b1;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
        lat   = 1;
        nbusy = 0;
        ovl   = 1'b0;
        while (done_v[w] !== 1'b1 && lat < 100) begin
            if (busy_v[w] === 1'b1) nbusy++;
            if (busy_v[w] === 1'b1 && done_v[w] === 1'b1) ovl = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (busy_v[w] === 1'b1 && done_v[w] === 1'b1) ovl = 1'b1;
        res = result_v[w];
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; mode_v[i] = 1'b0; ra_v[i] = 32'h0; amt_v[i] = 5'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || result_v[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: busy=%b done=%b result=%h, want 0 0 00000000",
                         i, busy_v[i], done_v[i], result_v[i]);
            end
        end
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_shl_long();
        int lat; int nb; logic [31:0] r; logic ov;
        run_op(0, 1'b0, 32'h0000_0001, 5'd31, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL shl31 result: got %h want 80000000", r); end
        n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL shl31 latency: got %0d want 32", lat); end
        n_cmp++; if (nb !== 31) begin n_err++; $display("FAIL shl31 busy cycles: got %0d want 31", nb); end
        n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL shl31 busy&done overlap: got %b want 0", ov); end
    endtask

    task automatic test_shl_nibble_and_zero();
        int lat; int nb; logic [31:0] r; logic ov;
        run_op(0, 1'b0, 32'hF0F0_F0F0, 5'd4, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h0F0F_0F00) begin n_err++; $display("FAIL shl4 result: got %h want 0f0f0f00", r); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL shl4 latency: got %0d want 5", lat); end
        n_cmp++; if (nb !== 4) begin n_err++; $display("FAIL shl4 busy cycles: got %0d want 4", nb); end
        run_op(0, 1'b0, 32'hF0F0_F0F0, 5'd0, lat, nb, r, ov);
        n_cmp++; if (r !== 32'hF0F0_F0F0) begin n_err++; $display("FAIL shl0 result: got %h want f0f0f0f0", r); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL shl0 latency: got %0d want 1", lat); end
        n_cmp++; if (nb !== 0) begin n_err++; $display("FAIL shl0 busy cycles: got %0d want 0", nb); end
        run_op(0, 1'b1, 32'h1234_5678, 5'd0, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h1234_5678 || lat !== 1) begin
            n_err++; $display("FAIL rol0: got %h lat %0d want 12345678 lat 1", r, lat);
        end
    endtask

    task automatic test_step4();
        int lat; int nb; logic [31:0] r; logic ov;
        run_op(1, 1'b1, 32'h8000_0001, 5'd31, lat, nb, r, ov);
        n_cmp++; if (r !== 32'hC000_0000) begin n_err++; $display("FAIL rol31 s4 result: got %h want c0000000", r); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL rol31 s4 latency: got %0d want 9", lat); end
        n_cmp++; if (nb !== 8) begin n_err++; $display("FAIL rol31 s4 busy cycles: got %0d want 8", nb); end
        n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL rol31 s4 overlap: got %b want 0", ov); end
        run_op(1, 1'b0, 32'h1234_5678, 5'd8, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h3456_7800 || lat !== 3) begin
            n_err++; $display("FAIL shl8 s4: got %h lat %0d want 34567800 lat 3", r, lat);
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        int lat; int nb; logic [31:0] r; logic ov;
        mode_v[0] = 1'b1; ra_v[0] = 32'hAAAA_AAAA; amt_v[0] = 5'd1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL rol1 busy: got %b want 1", busy_v[0]); end
        // Start during SHIFT with a different operand must be ignored.
        mode_v[0] = 1'b0; ra_v[0] = 32'h0; amt_v[0] = 5'd5; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        n_cmp++; if (done_v[0] !== 1'b1) begin n_err++; $display("FAIL rol1 done: got %b want 1", done_v[0]); end
        n_cmp++; if (result_v[0] !== 32'h5555_5555) begin
            n_err++; $display("FAIL rol1 result: got %h want 55555555", result_v[0]);
        end
        // Now in the done cycle: a start here is accepted immediately.
        run_op(0, 1'b0, 32'h0000_0003, 5'd2, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h0000_000C || lat !== 3) begin
            n_err++; $display("FAIL back_to_back: got %h lat %0d want 0000000c lat 3", r, lat);
        end
    endtask

    task automatic test_mid_reset();
        int lat; int nb; logic [31:0] r; logic ov; int ndone;
        run_op(2, 1'b1, 32'h8000_0000, 5'd5, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h0000_0010 || lat !== 4 || nb !== 3) begin
            n_err++; $display("FAIL rol5 s2: got %h lat %0d busy %0d want 00000010 lat 4 busy 3", r, lat, nb);
        end
        mode_v[2] = 1'b0; ra_v[2] = 32'hFFFF_FFFF; amt_v[2] = 5'd20; start_v[2] = 1'b1;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++; if (busy_v[2] !== 1'b1) begin n_err++; $display("FAIL midrst pre busy: got %b want 1", busy_v[2]); end
        clr_n = 1'b0;
        #1;
        n_cmp++; if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || result_v[2] !== 32'h0) begin
            n_err++; $display("FAIL midrst outputs: busy=%b done=%b result=%h want 0 0 00000000",
                              busy_v[2], done_v[2], result_v[2]);
        end
        #3;
        clr_n = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        repeat (15) begin
            if (done_v[2] === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL midrst stray done: got %0d want 0", ndone); end
        run_op(2, 1'b0, 32'h0000_0001, 5'd3, lat, nb, r, ov);
        n_cmp++; if (r !== 32'h0000_0008 || lat !== 3) begin
            n_err++; $display("FAIL post reset op: got %h lat %0d want 00000008 lat 3", r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_shl_long();
        test_shl_nibble_and_zero();
        test_step4();
        test_ignore_and_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
